// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan decoder and the display
// block's self-test:
//   - SEG_0 .. SEG_F : active-low cathode patterns (bit0=a .. bit6=g)
//   - SEG_BLANK      : full cathode byte with every segment and DP off
//   - seg_state_e    : scan decoder FSM states
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,  // no digit selected (blank or conflict)
        ST_SETTLE = 2'd1,  // one digit selected, waiting for stable pair
        ST_HOLD   = 2'd2   // dwell captured, waiting for the pair to change
    } seg_state_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg_pattern_decode
// Combinational lookup from an active-low seven-segment pattern to a hex
// nibble. Patterns outside the sixteen hex glyphs report valid_o = 0 with a
// zero nibble.
//   seg_i    [6:0] : active-low segments, bit0=a .. bit6=g
//   valid_o        : 1 when seg_i is one of the sixteen hex glyphs
//   nibble_o [3:0] : decoded value (0 when not valid)
// -----------------------------------------------------------------------------
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        valid_o  = 1'b1;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_0:   nibble_o = 4'h0;
            SEG_1:   nibble_o = 4'h1;
            SEG_2:   nibble_o = 4'h2;
            SEG_3:   nibble_o = 4'h3;
            SEG_4:   nibble_o = 4'h4;
            SEG_5:   nibble_o = 4'h5;
            SEG_6:   nibble_o = 4'h6;
            SEG_7:   nibble_o = 4'h7;
            SEG_8:   nibble_o = 4'h8;
            SEG_9:   nibble_o = 4'h9;
            SEG_A:   nibble_o = 4'hA;
            SEG_B:   nibble_o = 4'hB;
            SEG_C:   nibble_o = 4'hC;
            SEG_D:   nibble_o = 4'hD;
            SEG_E:   nibble_o = 4'hE;
            SEG_F:   nibble_o = 4'hF;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Watches a multiplexed, active-low seven-segment scan bus, waits for each
// digit dwell to be stable for SETTLE cycles, decodes the glyph and stores
// it in the slot of the selected digit. Reports frame completion once every
// digit position has been captured.
//
// Parameters:
//   DIGITS : number of anode lines / digit slots
//   SETTLE : consecutive identical cycles required before a capture (>= 2)
//
// Ports:
//   clock                  : rising-edge clock
//   reset                  : synchronous, active-high
//   anode_in   [DIGITS-1:0]: active-low digit enables
//   cathode_in [7:0]       : active-low segments, bit7 = decimal point
//   digits_out [4*DIGITS-1:0] : decoded nibble per slot
//   dp_out     [DIGITS-1:0]: captured decimal point per slot (1 = lit)
//   digit_seen [DIGITS-1:0]: slots captured in the current frame
//   frame_done             : one-cycle pulse on the capture completing a frame
//   seg_err                : sticky; bad glyph or anode conflict seen
//
// Build option:
//   SEG_DP_CAPTURE_EN : when defined, the decimal point is captured and takes
//                       part in the stability compare; otherwise dp_out is 0
//                       and cathode_in[7] is ignored.
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int SETTLE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     anode_in,
    input  logic [7:0]            cathode_in,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_seen,
    output logic                  frame_done,
    output logic                  seg_err
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE);

    // Registered state
    seg_state_e              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIGITS+7:0]       prev_pair_q;
    logic [4*DIGITS-1:0]     digits_q;
    logic [DIGITS-1:0]       seen_q;
    logic                    frame_done_q;
    logic                    seg_err_q;

    // Combinational helpers
    logic [DIGITS+7:0]       pair;
    logic [DIGITS-1:0]       an_active;
    logic                    an_onehot;
    logic                    an_conflict;
    logic                    pair_same;
    logic                    capture;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS-1:0]       seen_d;
    logic                    frame_full;
    logic                    dec_valid;
    logic [3:0]              dec_nibble;

    // The pair that must stay constant for a dwell to count as settled.
`ifdef SEG_DP_CAPTURE_EN
    assign pair = {anode_in, cathode_in};
`else
    // DP bit is forced constant so DP flicker never restarts the settle.
    assign pair = {anode_in, 1'b1, cathode_in[6:0]};
    logic unused_dp;
    assign unused_dp = cathode_in[7];
`endif

    assign an_active   = ~anode_in;
    // x & (x-1) clears the lowest set bit: non-zero means two or more digits.
    assign an_conflict = (an_active & (an_active - DIGITS'(1))) != '0;
    assign an_onehot   = (an_active != '0) && !an_conflict;
    assign pair_same   = (pair == prev_pair_q);
    assign capture     = (state_q == ST_SETTLE) && an_onehot && pair_same &&
                         (cnt_q == CNT_MAX);

    // Slot index of the selected digit; only meaningful when an_onehot.
    always_comb begin
        idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_active[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign seen_d     = seen_q | an_active;
    assign frame_full = &seen_d;

    seg_pattern_decode u_decode (
        .seg_i    (cathode_in[6:0]),
        .valid_o  (dec_valid),
        .nibble_o (dec_nibble)
    );

`ifdef SEG_DP_CAPTURE_EN
    logic [DIGITS-1:0] dp_q;
    assign dp_out = dp_q;
`else
    assign dp_out = '0;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the slot registers are reset too; they drive observable
            // outputs that must read zero until the first capture.
            state_q      <= ST_WAIT;
            cnt_q        <= '0;
            prev_pair_q  <= '0;
            digits_q     <= '0;
            seen_q       <= '0;
            frame_done_q <= 1'b0;
            seg_err_q    <= 1'b0;
`ifdef SEG_DP_CAPTURE_EN
            dp_q         <= '0;
`endif
        end else begin
            prev_pair_q  <= pair;
            frame_done_q <= 1'b0;

            if (an_conflict || (capture && !dec_valid)) begin
                seg_err_q <= 1'b1;
            end

            case (state_q)
                ST_WAIT: begin
                    if (an_onehot) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (!an_onehot) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end else if (!pair_same) begin
                        cnt_q   <= CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Capture; an unknown glyph still fills its slot with 0.
                        digits_q[4*idx +: 4] <= dec_valid ? dec_nibble : 4'h0;
`ifdef SEG_DP_CAPTURE_EN
                        dp_q[idx] <= ~cathode_in[7];
`endif
                        if (frame_full) begin
                            seen_q       <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            seen_q       <= seen_d;
                        end
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    // Counter stays at CNT_MAX here, so it cannot wrap.
                    if (!pair_same) begin
                        if (an_onehot) begin
                            cnt_q   <= CNT_ONE;
                            state_q <= ST_SETTLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= ST_WAIT;
                        end
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign digits_out = digits_q;
    assign digit_seen = seen_q;
    assign frame_done = frame_done_q;
    assign seg_err    = seg_err_q;

endmodule
